mult_2x3_seq_ctrl: RTL and testbench

//  Sequential 3-bit x 2-bit unsigned multiplier controller: one partial-product row per clock.

---
 rtl/mult_pkg.sv | 19 +
 rtl/mult_row_adder.sv | 40 ++++
 rtl/mult_2x3_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mult_2x3_seq_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential 3x2 multiplier controller slice:
// default operand widths and the controller state encoding.
// ---------------------------------------------------------------------------
package mult_pkg;

  // Default operand widths; the multiplier width is also the row-cycle count.
  localparam int M_WIDTH_DEF = 3;
  localparam int Q_WIDTH_DEF = 2;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROW  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult_row_adder.sv
// ---------------------------------------------------------------------------
// mult_row_adder
// Combinational partial-product row: gates the multiplicand with one
// multiplier bit and adds the result to an accumulator slice through a
// ripple chain of full-adder cells, one cell per bit.
//
// Ports
//   m_i        in  WIDTH  multiplicand
//   qBit_i     in  1      current multiplier bit
//   accSlice_i in  WIDTH  accumulator bits aligned to this row
//   cin_i      in  1      carry into bit 0 (tied low by the controller)
//   sum_o      out WIDTH  row sum slice
//   cout_o     out 1      carry out of the top cell
// ---------------------------------------------------------------------------
module mult_row_adder #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] m_i,
  input  logic             qBit_i,
  input  logic [WIDTH-1:0] accSlice_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin_i;

  // One AND gate plus one full adder per bit position.
  for (genvar i = 0; i < WIDTH; i++) begin : gBit
    logic pp;
    assign pp           = m_i[i] & qBit_i;
    assign sum_o[i]     = pp ^ accSlice_i[i] ^ carry[i];
    assign carry[i + 1] = (pp & accSlice_i[i]) | (carry[i] & (pp ^ accSlice_i[i]));
  end

  assign cout_o = carry[WIDTH];

endmodule

// File: rtl/mult_2x3_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mult_2x3_seq_ctrl
// Sequential unsigned multiplier controller: accepts an operand pair under a
// valid/ready handshake, adds one partial-product row per clock, and holds
// the product under a valid/ready handshake until downstream takes it.
//
// Optional feature macro: MULT_ZERO_SKIP_EN
//   When defined, a zero multiplicand or multiplier bypasses the row cycles
//   and goes straight to DONE with a zero product.
//
// Ports
//   clock      in   1        system clock, rising edge
//   reset      in   1        synchronous active-high reset
//   in_valid   in   1        operands valid
//   in_ready   out  1        controller can accept operands (IDLE only)
//   m_in       in   M_WIDTH  multiplicand
//   q_in       in   Q_WIDTH  multiplier
//   out_valid  out  1        product valid
//   out_ready  in   1        downstream accepts product
//   product    out  P_WIDTH  m*q, unsigned
//   busy       out  1        high in ROW or DONE
// ---------------------------------------------------------------------------
module mult_2x3_seq_ctrl
  import mult_pkg::*;
#(
  parameter  int M_WIDTH = M_WIDTH_DEF,
  parameter  int Q_WIDTH = Q_WIDTH_DEF,
  localparam int P_WIDTH = M_WIDTH + Q_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [M_WIDTH-1:0] m_in,
  input  logic [Q_WIDTH-1:0] q_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] product,
  output logic               busy
);

  localparam int ROW_W = (Q_WIDTH > 1) ? $clog2(Q_WIDTH) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(Q_WIDTH - 1);

  state_e             state_q;
  logic [M_WIDTH-1:0] mReg_q;
  logic [Q_WIDTH-1:0] qReg_q;
  logic [P_WIDTH-1:0] acc_q;
  logic [P_WIDTH-1:0] acc_d;
  logic [P_WIDTH-1:0] product_q;
  logic [ROW_W-1:0]   rowIdx_q;
  logic               inReady_q;
  logic               outValid_q;
  logic               busy_q;

  logic               qBit;
  logic [M_WIDTH-1:0] accSlice;
  logic [M_WIDTH-1:0] rowSum;
  logic               rowCout;
  logic [P_WIDTH-1:0] rowTerm;
  logic [P_WIDTH-1:0] lowMask;

  // The single row adder is reused every ROW cycle; the accumulator is
  // shifted down so the adder always sees the bits aligned to this row.
  assign qBit     = qReg_q[rowIdx_q];
  assign accSlice = M_WIDTH'(acc_q >> rowIdx_q);

  mult_row_adder #(
    .WIDTH(M_WIDTH)
  ) u_rowAdder (
    .m_i       (mReg_q),
    .qBit_i    (qBit),
    .accSlice_i(accSlice),
    .cin_i     (1'b0),
    .sum_o     (rowSum),
    .cout_o    (rowCout)
  );

  // Reassemble the accumulator: bits below the row are untouched, the row
  // sum replaces the aligned slice, and the carry lands at row+M_WIDTH.
  // Bits above that are always zero at this point, so no merge is needed.
  always_comb begin
    rowTerm = P_WIDTH'({rowCout, rowSum}) << rowIdx_q;
    lowMask = ~({P_WIDTH{1'b1}} << rowIdx_q);
    acc_d   = (acc_q & lowMask) | rowTerm;
  end

`ifdef MULT_ZERO_SKIP_EN
  logic zeroOperand;
  assign zeroOperand = (m_in == '0) || (q_in == '0);
`endif

  // Controller FSM with registered handshake and status outputs.
  // out_valid rises one cycle after entering DONE, and the handoff only
  // happens once out_valid has actually been presented downstream.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mReg_q     <= '0;
      qReg_q     <= '0;
      acc_q      <= '0;
      rowIdx_q   <= '0;
      product_q  <= '0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && inReady_q) begin
            mReg_q    <= m_in;
            qReg_q    <= q_in;
            acc_q     <= '0;
            rowIdx_q  <= '0;
            inReady_q <= 1'b0;
            busy_q    <= 1'b1;
`ifdef MULT_ZERO_SKIP_EN
            if (zeroOperand) begin
              state_q   <= ST_DONE;
              product_q <= '0;
            end else begin
              state_q <= ST_ROW;
            end
`else
            state_q <= ST_ROW;
`endif
          end
        end

        ST_ROW: begin
          acc_q    <= acc_d;
          rowIdx_q <= rowIdx_q + ROW_W'(1);
          if (rowIdx_q == LAST_ROW) begin
            state_q   <= ST_DONE;
            product_q <= acc_d;
          end
        end

        ST_DONE: begin
          if (outValid_q && out_ready) begin
            state_q    <= ST_IDLE;
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            outValid_q <= 1'b1;
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          inReady_q  <= 1'b1;
          outValid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign product   = product_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mult_2x3_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mult_2x3_seq_ctrl
// Directed self-checking bench for the sequential 3x2 multiplier controller.
// Honours MULT_ZERO_SKIP_EN when choosing expected zero-operand latency.
// ---------------------------------------------------------------------------
module tb_mult_2x3_seq_ctrl;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] m_in;
  logic [1:0] q_in;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] product;
  logic       busy;

  int assertCount = 0;
  int failCount   = 0;

`ifdef MULT_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  mult_2x3_seq_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .m_in     (m_in),
    .q_in     (q_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one cycle and settle just after the rising edge.
  task automatic stepClock();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Present one operand pair for exactly one accepting edge.
  task automatic applyStimulus(input int m, input int q);
    in_valid = 1'b1;
    m_in     = 3'(m);
    q_in     = 2'(q);
    stepClock();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid and check latency and product.
  task automatic waitProduct(input string tag, input int expProd, input int expLat);
    int cycles = 0;
    while (out_valid !== 1'b1 && cycles < 12) begin
      stepClock();
      cycles++;
    end
    checkOutput({tag, "_lat"}, cycles, expLat);
    checkOutput({tag, "_prod"}, int'(product), expProd);
  endtask

  function automatic int expLatency(input int m, input int q);
    return (ZERO_SKIP && (m == 0 || q == 0)) ? 1 : 3;
  endfunction

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    m_in      = '0;
    q_in      = '0;
    out_ready = 1'b1;
    stepClock();
    stepClock();

    // Reset state.
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_product", int'(product), 0);
    checkOutput("rst_busy", int'(busy), 0);
    reset = 1'b0;
    stepClock();

    // 1: 3*3 with immediate handoff.
    applyStimulus(3, 3);
    checkOutput("t1_in_ready_busy", int'(in_ready), 0);
    checkOutput("t1_busy", int'(busy), 1);
    waitProduct("t1", 9, 3);
    stepClock();
    checkOutput("t1_out_valid_after", int'(out_valid), 0);
    checkOutput("t1_in_ready_after", int'(in_ready), 1);
    checkOutput("t1_busy_after", int'(busy), 0);

    // 2: maximum product, then full sweep.
    applyStimulus(7, 3);
    waitProduct("t2_max", 21, 3);
    stepClock();
    for (int m = 0; m < 8; m++) begin
      for (int q = 0; q < 4; q++) begin
        applyStimulus(m, q);
        waitProduct($sformatf("sweep_%0dx%0d", m, q), m * q, expLatency(m, q));
        stepClock();
      end
    end

    // 3: backpressure holds DONE.
    out_ready = 1'b0;
    applyStimulus(5, 2);
    waitProduct("t3", 10, 3);
    for (int i = 0; i < 6; i++) begin
      stepClock();
      checkOutput($sformatf("t3_hold_valid_%0d", i), int'(out_valid), 1);
      checkOutput($sformatf("t3_hold_prod_%0d", i), int'(product), 10);
      checkOutput($sformatf("t3_hold_in_ready_%0d", i), int'(in_ready), 0);
    end
    out_ready = 1'b1;
    stepClock();
    checkOutput("t3_release_valid", int'(out_valid), 0);
    checkOutput("t3_release_in_ready", int'(in_ready), 1);

    // 4: reset during ROW abandons the operation.
    applyStimulus(6, 3);
    reset = 1'b1;
    stepClock();
    reset = 1'b0;
    checkOutput("t4_in_ready", int'(in_ready), 1);
    checkOutput("t4_out_valid", int'(out_valid), 0);
    checkOutput("t4_product", int'(product), 0);
    checkOutput("t4_busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) stepClock();
    checkOutput("t4_no_emit", int'(out_valid), 0);
    applyStimulus(1, 1);
    waitProduct("t4_next", 1, 3);
    stepClock();

    // Reset and in_valid together: operands not latched.
    reset    = 1'b1;
    in_valid = 1'b1;
    m_in     = 3'd7;
    q_in     = 2'd3;
    stepClock();
    reset    = 1'b0;
    in_valid = 1'b0;
    checkOutput("rstv_busy", int'(busy), 0);
    stepClock();
    checkOutput("rstv_busy_later", int'(busy), 0);
    checkOutput("rstv_in_ready", int'(in_ready), 1);

    // 5: zero multiplicand.
    applyStimulus(0, 3);
    waitProduct("t5_zero", 0, ZERO_SKIP ? 1 : 3);
    stepClock();

    // 6: operands changing while busy are ignored.
    begin
      int cycles = 0;
      in_valid = 1'b1;
      m_in     = 3'd2;
      q_in     = 2'd3;
      stepClock();
      while (out_valid !== 1'b1 && cycles < 12) begin
        m_in = 3'($urandom_range(7, 0));
        q_in = 2'($urandom_range(3, 0));
        stepClock();
        cycles++;
      end
      in_valid = 1'b0;
      checkOutput("t6_lat", cycles, 3);
      checkOutput("t6_prod", int'(product), 6);
      checkOutput("t6_in_ready", int'(in_ready), 0);
      stepClock();
      checkOutput("t6_out_valid_after", int'(out_valid), 0);
      stepClock();
      checkOutput("t6_no_second_op", int'(busy), 0);
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
